// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the UART command-frame receiver.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OP      = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4
    } rx_state_t;

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_FRAMING  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte watchdog: counts while enabled, cleared on each byte or when idle.
module rx_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_r;

    // Count cycles since the last byte; park at the limit so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear || !enable) begin
            count_r <= '0;
        end else if (count_r != LIMIT) begin
            count_r <= count_r + TW'(1);
        end
    end

    assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Assembles SYNC/opcode/payload/checksum byte frames into a held command.
// Optional RX_FRAME_STATS_EN builds saturating frame/error counters.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       cmd_ready,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_op,
    output logic [8*PAYLOAD_BYTES-1:0] cmd_payload,
    output logic                       busy,
    output logic                       err_pulse,
    output logic [1:0]                 err_code,
    output logic [7:0]                 stat_frames,
    output logic [7:0]                 stat_errors
);

    localparam int IW = $clog2(PAYLOAD_BYTES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

    rx_state_t     state_r;
    logic [IW-1:0] idx_r;
    logic [7:0]    xor_r;

    logic          tmr_en_s;
    logic          tmr_expired_s;
    logic          frame_err_s;
    logic [1:0]    frame_err_code_s;
    logic          overrun_s;
    logic          handshake_s;
    logic          err_event_s;

    assign tmr_en_s    = (state_r == ST_OP) || (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
    assign overrun_s   = (state_r == ST_HOLD) && rx_done;
    assign handshake_s = cmd_valid && cmd_ready;
    assign err_event_s = frame_err_s || overrun_s;

    rx_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_done),
        .enable (tmr_en_s),
        .expired(tmr_expired_s)
    );

    // Classify in-frame errors; a byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        frame_err_s      = 1'b0;
        frame_err_code_s = ERR_CHECKSUM;
        case (state_r)
            ST_OP, ST_PAYLOAD, ST_CHECK: begin
                if (rx_done) begin
                    if (!rx_valid) begin
                        frame_err_s      = 1'b1;
                        frame_err_code_s = ERR_FRAMING;
                    end else if ((state_r == ST_CHECK) && (rx_data != xor_r)) begin
                        frame_err_s      = 1'b1;
                        frame_err_code_s = ERR_CHECKSUM;
                    end else begin
                        frame_err_s      = 1'b0;
                    end
                end else if (tmr_expired_s) begin
                    frame_err_s      = 1'b1;
                    frame_err_code_s = ERR_TIMEOUT;
                end else begin
                    frame_err_s      = 1'b0;
                end
            end
            default: begin
                frame_err_s      = 1'b0;
                frame_err_code_s = ERR_CHECKSUM;
            end
        endcase
    end

    // Frame FSM with registered command, busy and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            xor_r       <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_op      <= 8'd0;
            cmd_payload <= '0;
            busy        <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_CHECKSUM;
        end else begin
            err_pulse <= err_event_s;
            if (frame_err_s) begin
                err_code <= frame_err_code_s;
            end else if (overrun_s) begin
                err_code <= ERR_OVERRUN;
            end

            if (frame_err_s) begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rx_done && rx_valid && (rx_data == SYNC_BYTE)) begin
                            state_r <= ST_OP;
                            busy    <= 1'b1;
                        end
                    end
                    ST_OP: begin
                        if (rx_done) begin
                            cmd_op  <= rx_data;
                            xor_r   <= rx_data;
                            idx_r   <= '0;
                            state_r <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_done) begin
                            for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
                                if (idx_r == IW'(i)) begin
                                    cmd_payload[8*i +: 8] <= rx_data;
                                end
                            end
                            xor_r <= xor_r ^ rx_data;
                            idx_r <= idx_r + IW'(1);
                            if (idx_r == LAST_IDX) begin
                                state_r <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (rx_done) begin
                            state_r   <= ST_HOLD;
                            cmd_valid <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (handshake_s) begin
                            state_r   <= ST_IDLE;
                            busy      <= 1'b0;
                            cmd_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RX_FRAME_STATS_EN
    logic [7:0] frames_r;
    logic [7:0] errors_r;

    // Saturating delivered-frame and error-event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_r <= 8'd0;
            errors_r <= 8'd0;
        end else begin
            if (handshake_s) begin
                frames_r <= sat_inc8(frames_r);
            end
            if (err_event_s) begin
                errors_r <= sat_inc8(errors_r);
            end
        end
    end

    assign stat_frames = frames_r;
    assign stat_errors = errors_r;
`else
    assign stat_frames = 8'd0;
    assign stat_errors = 8'd0;
`endif

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 PAYLOAD_BYTES, 4, payload bytes per frame (legal 1..16).
REQ-002 TIMEOUT_CYCLES, 50000, max clk cycles allowed between consecutive in-frame bytes.
REQ-003 SYNC_BYTE, 8'hA5, frame start marker.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_done  input  1  one-cycle byte strobe from UART receiver.
REQ-007 rx_valid  input  1  byte free of framing error; sampled only with rx_done.
REQ-008 rx_data  input  8  received byte; sampled only with rx_done.
REQ-009 cmd_valid  output  1  assembled command pending.
REQ-010 cmd_ready  input  1  consumer accept; handshake = cmd_valid & cmd_ready.
REQ-011 cmd_op  output  8  command opcode.
REQ-012 cmd_payload  output  8*PAYLOAD_BYTES  payload; first payload byte in [7:0].
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 err_pulse  output  1  one-cycle error strobe.
REQ-015 err_code  output  2  last error cause: 0 checksum, 1 framing, 2 timeout, 3 overrun; held until next error.
REQ-016 stat_frames  output  8  delivered-frame count (see Configuration).
REQ-017 stat_errors  output  8  error-event count (see Configuration).

Function
REQ-018 Frame: SYNC_BYTE, opcode, PAYLOAD_BYTES payload bytes, checksum = XOR of opcode and all payload bytes.
REQ-019 States IDLE, OP, PAYLOAD, CHECK, HOLD; unused encodings go to IDLE next cycle.
REQ-020 IDLE: rx_done & rx_valid & rx_data==SYNC_BYTE -> OP; any other byte silently discarded, no error.
REQ-021 OP: valid byte loads cmd_op, seeds running XOR, clears byte index -> PAYLOAD.
REQ-022 PAYLOAD: valid byte stored at byte index, XOR updated, index +1; after byte PAYLOAD_BYTES-1 -> CHECK.
REQ-023 CHECK: valid byte equal to XOR -> HOLD, cmd_valid high on the next cycle (1-cycle latency); mismatch -> error code 0.
REQ-024 OP/PAYLOAD/CHECK: rx_done with rx_valid=0 -> error code 1.
REQ-025 Inter-byte timer cleared on every rx_done, runs only in OP/PAYLOAD/CHECK; reaching TIMEOUT_CYCLES-1 -> error code 2.
REQ-026 Error in OP/PAYLOAD/CHECK: err_pulse high exactly one cycle, err_code updated same cycle, state -> IDLE, partial frame never presented.
REQ-027 HOLD: cmd_valid, cmd_op, cmd_payload stable until handshake; handshake -> IDLE, cmd_valid low next cycle.
REQ-028 rx_done in HOLD: byte dropped, err_pulse with code 3, pending command retained, HOLD kept.
REQ-029 rx_done coincident with handshake: command completes -> IDLE, byte dropped as overrun (code 3).
REQ-030 Timer width ceil(log2(TIMEOUT_CYCLES))+1; index width ceil(log2(PAYLOAD_BYTES))+1; no wrap before compare.

Reset
REQ-031 rst asserted: immediately, without clock edge, state IDLE; cmd_valid, busy, err_pulse, err_code, cmd_op, cmd_payload, timer, index, XOR, stat counters all 0.
REQ-032 Reset mid-frame or in HOLD discards the frame; no err_pulse caused by reset assertion or release.

Configuration
REQ-033 RX_FRAME_STATS_EN defined: stat_frames +1 per handshake, stat_errors +1 per err_pulse, both saturate at 255.
REQ-034 RX_FRAME_STATS_EN undefined: counters not built, stat_frames and stat_errors tied to 0; all other behaviour identical.

Structure
REQ-035 Package rx_frame_pkg holds state enum, ERR_CHECKSUM/ERR_FRAMING/ERR_TIMEOUT/ERR_OVERRUN constants, default SYNC_BYTE.
REQ-036 One sub-module rx_frame_timer: inter-byte timeout counter with clear, enable inputs and expired output.

Verification
REQ-037 PAYLOAD_BYTES=4, cmd_ready=1: bytes A5,10,01,02,03,04,14 -> one cmd_valid cycle, cmd_op=0x10, cmd_payload=0x04030201.
REQ-038 Same frame, checksum 0x15 -> err_pulse, err_code=0, no cmd_valid, busy low next cycle.
REQ-039 TIMEOUT_CYCLES=100: A5,10 then silence -> err_code=2 after 100 cycles; following good frame delivered normally.
REQ-040 Good frame, cmd_ready=0, extra byte 0x55 -> err_code=3, cmd_valid held with 0x10/0x04030201; cmd_ready=1 -> accepted once.
REQ-041 rx_valid=0 on third byte -> err_code=1; rst pulsed mid-payload -> outputs at reset values before next clock edge.
REQ-042 RX_FRAME_STATS_EN defined, 300 good frames -> stat_frames=255; undefined -> stat_frames=0 throughout.
